// File: rtl/bch_eras_pkg.sv
// Shared types and defaults for the BCH erasure decoder buffer pool.
// Locator polynomial buses are packed flat: coefficient j of variant k sits at bits [(k*(t+1)+j)*m +: m].
package bch_eras_pkg;

    typedef enum logic [1:0] {
        BUF_FREE    = 2'd0,
        BUF_FILL    = 2'd1,
        BUF_WAIT_BM = 2'd2,
        BUF_SEARCH  = 2'd3
    } buf_state_t;

    localparam int M_DEF     = 4;
    localparam int N_DEF     = 15;
    localparam int D_DEF     = 7;
    localparam int PTR_W_DEF = 1;
    localparam int T_DEF     = (D_DEF - 1) / 2;

    typedef logic [PTR_W_DEF-1:0] ptr_t;
    typedef logic [M_DEF-1:0]     data_t;

endpackage

// File: rtl/bch_eras_ptr_fifo.sv
// Two-entry FIFO of buffer pointers in Chien-search order; a pop on empty and a push on full
// without a simultaneous pop are dropped.
module bch_eras_ptr_fifo
    import bch_eras_pkg::*;
#(
    parameter int ptr_w = PTR_W_DEF
) (
    input  logic             iclk,
    input  logic             ireset_n,
    input  logic             iclkena,
    input  logic             ipush,
    input  logic             ipop,
    input  logic [ptr_w-1:0] idat,
    output logic [ptr_w-1:0] ohead,
    output logic             ofull,
    output logic             oempty
);

    logic [ptr_w-1:0] mem [2];
    logic             wr_idx;
    logic             rd_idx;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign oempty  = (cnt == 2'd0);
    assign ofull   = (cnt == 2'd2);
    assign do_pop  = ipop & ~oempty;
    assign do_push = ipush & (~ofull | do_pop);
    assign ohead   = mem[rd_idx];

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            cnt    <= 2'd0;
        end else if (iclkena) begin
            if (do_push) wr_idx <= ~wr_idx;
            if (do_pop)  rd_idx <= ~rd_idx;
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge iclk) begin
        if (iclkena && do_push) mem[wr_idx] <= idat;
    end

endmodule

// File: rtl/bch_eras_buf_sched.sv
// Frame buffer pool scheduler: round-robin allocation to the writer, one-deep BM holding
// register, Chien issue pacing every n enabled cycles, and release on Chien end-of-frame.
module bch_eras_buf_sched
    import bch_eras_pkg::*;
#(
    parameter int m     = M_DEF,
    parameter int n     = N_DEF,
    parameter int d     = D_DEF,
    parameter int ptr_w = PTR_W_DEF
) (
    input  logic                           iclk,
    input  logic                           ireset_n,
    input  logic                           iclkena,
    input  logic                           iwr_sop,
    input  logic                           iwr_eop,
    output logic                           owr_rdy,
    output logic [ptr_w-1:0]               owr_ptr,
    input  logic                           ibm_val,
    input  logic [ptr_w-1:0]               ibm_ptr,
    input  logic [2*((d-1)/2+1)*m-1:0]     ibm_poly,
    output logic                           obm_rdy,
    output logic                           oloc_poly_val,
    output logic [ptr_w-1:0]               oloc_poly_ptr,
    output logic [2*((d-1)/2+1)*m-1:0]     oloc_poly,
    input  logic                           ich_eof,
    output logic                           obusy,
    output logic [2:0]                     oerr
);

    localparam int t      = (d - 1) / 2;
    localparam int nbuf   = 2 ** ptr_w;
    localparam int poly_w = 2 * (t + 1) * m;
    localparam int gap_w  = $clog2(n);
    localparam logic [gap_w-1:0] gap_load = gap_w'(n - 1);

    buf_state_t        buf_st     [nbuf];
    buf_state_t        buf_st_nxt [nbuf];
    logic [ptr_w-1:0]  alloc_ptr;
    logic [ptr_w-1:0]  fill_ptr;
    logic              fill_open;
    logic              hold_val;
    logic [ptr_w-1:0]  hold_ptr;
    logic [poly_w-1:0] hold_poly;
    logic [gap_w-1:0]  gap;
    logic              ch_free;
    logic              issue;
    logic              sop_ok;
    logic              eop_ok;
    logic              bm_acc;
    logic              rel;
    logic [ptr_w-1:0]  fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2:0]        err_set;

    // An eop in the same cycle closes the fill before the sop is judged.
    assign owr_rdy = (buf_st[alloc_ptr] == BUF_FREE) & (~fill_open | iwr_eop);
    assign owr_ptr = alloc_ptr;
    assign eop_ok  = iclkena & iwr_eop & fill_open;
    assign sop_ok  = iclkena & iwr_sop & owr_rdy;

    assign ch_free = (gap == '0);
    assign issue   = iclkena & hold_val & ch_free;
    assign obm_rdy = ~hold_val | issue;
    assign bm_acc  = iclkena & ibm_val & obm_rdy;
    assign rel     = iclkena & ich_eof & ~fifo_empty;

    assign err_set[0] = iclkena & ((iwr_sop & ~owr_rdy) | (iwr_eop & ~fill_open));
    assign err_set[1] = bm_acc & (buf_st[ibm_ptr] != BUF_WAIT_BM);
    assign err_set[2] = iclkena & ((ich_eof & fifo_empty) | (issue & fifo_full & ~ich_eof));

    always_comb begin
        for (int i = 0; i < nbuf; i++) buf_st_nxt[i] = buf_st[i];
        if (rel)    buf_st_nxt[fifo_head] = BUF_FREE;
        if (eop_ok) buf_st_nxt[fill_ptr]  = BUF_WAIT_BM;
        if (issue)  buf_st_nxt[hold_ptr]  = BUF_SEARCH;
        if (sop_ok) buf_st_nxt[alloc_ptr] = BUF_FILL;
    end

    always_comb begin
        obusy = 1'b0;
        for (int i = 0; i < nbuf; i++) begin
            if (buf_st[i] != BUF_FREE) obusy = 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            for (int i = 0; i < nbuf; i++) buf_st[i] <= BUF_FREE;
            alloc_ptr     <= '0;
            fill_ptr      <= '0;
            fill_open     <= 1'b0;
            hold_val      <= 1'b0;
            hold_ptr      <= '0;
            gap           <= '0;
            oloc_poly_val <= 1'b0;
            oloc_poly_ptr <= '0;
            oloc_poly     <= '0;
            oerr          <= '0;
        end else if (iclkena) begin
            for (int i = 0; i < nbuf; i++) buf_st[i] <= buf_st_nxt[i];
            if (sop_ok) begin
                alloc_ptr <= alloc_ptr + 1'b1;
                fill_ptr  <= alloc_ptr;
            end
            fill_open <= sop_ok | (fill_open & ~eop_ok);
            if (bm_acc) begin
                hold_val <= 1'b1;
                hold_ptr <= ibm_ptr;
            end else if (issue) begin
                hold_val <= 1'b0;
            end
            // Reload n-1 so consecutive issues land exactly n enabled cycles apart.
            if (issue)            gap <= gap_load;
            else if (gap != '0)   gap <= gap - 1'b1;
            oloc_poly_val <= issue;
            if (issue) begin
                oloc_poly_ptr <= hold_ptr;
                oloc_poly     <= hold_poly;
            end
            oerr <= oerr | err_set;
        end
    end

    always_ff @(posedge iclk) begin
        if (bm_acc) hold_poly <= ibm_poly;
    end

    bch_eras_ptr_fifo #(
        .ptr_w (ptr_w)
    ) u_search_fifo (
        .iclk     (iclk),
        .ireset_n (ireset_n),
        .iclkena  (iclkena),
        .ipush    (issue),
        .ipop     (iclkena & ich_eof),
        .idat     (hold_ptr),
        .ohead    (fifo_head),
        .ofull    (fifo_full),
        .oempty   (fifo_empty)
    );

endmodule

// File: tb/tb_bch_eras_buf_sched.sv
// Scoreboard bench for bch_eras_buf_sched: BM results queue the expected Chien issue
// (pointer, polynomials, cycle) and a monitor checks each oloc_poly_val pulse against it.
module tb_bch_eras_buf_sched;

    localparam int M     = 4;
    localparam int N     = 15;
    localparam int D     = 7;
    localparam int PTR_W = 1;
    localparam int PW    = 2 * ((D - 1) / 2 + 1) * M;

    logic             iclk = 1'b0;
    logic             ireset_n = 1'b0;
    logic             iclkena = 1'b1;
    logic             iwr_sop = 1'b0;
    logic             iwr_eop = 1'b0;
    logic             owr_rdy;
    logic [PTR_W-1:0] owr_ptr;
    logic             ibm_val = 1'b0;
    logic [PTR_W-1:0] ibm_ptr = '0;
    logic [PW-1:0]    ibm_poly = '0;
    logic             obm_rdy;
    logic             oloc_poly_val;
    logic [PTR_W-1:0] oloc_poly_ptr;
    logic [PW-1:0]    oloc_poly;
    logic             ich_eof = 1'b0;
    logic             obusy;
    logic [2:0]       oerr;

    typedef struct {
        logic [PTR_W-1:0] ptr;
        logic [PW-1:0]    poly;
        int               cyc;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    bch_eras_buf_sched #(
        .m     (M),
        .n     (N),
        .d     (D),
        .ptr_w (PTR_W)
    ) dut (
        .iclk          (iclk),
        .ireset_n      (ireset_n),
        .iclkena       (iclkena),
        .iwr_sop       (iwr_sop),
        .iwr_eop       (iwr_eop),
        .owr_rdy       (owr_rdy),
        .owr_ptr       (owr_ptr),
        .ibm_val       (ibm_val),
        .ibm_ptr       (ibm_ptr),
        .ibm_poly      (ibm_poly),
        .obm_rdy       (obm_rdy),
        .oloc_poly_val (oloc_poly_val),
        .oloc_poly_ptr (oloc_poly_ptr),
        .oloc_poly     (oloc_poly),
        .ich_eof       (ich_eof),
        .obusy         (obusy),
        .oerr          (oerr)
    );

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    always @(negedge iclk) begin
        exp_t e;
        if (ireset_n && oloc_poly_val) begin
            if (exp_q.size() == 0) begin
                check_val("issue_unexpected", 64'(oloc_poly_val), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("issue_ptr", 64'(oloc_poly_ptr), 64'(e.ptr));
                check_val("issue_poly", 64'(oloc_poly), 64'(e.poly));
                if (e.cyc >= 0) check_val("issue_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic do_reset();
        ireset_n = 1'b0;
        iwr_sop  = 1'b0;
        iwr_eop  = 1'b0;
        ibm_val  = 1'b0;
        ich_eof  = 1'b0;
        iclkena  = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        ireset_n = 1'b1;
        tick();
    endtask

    task automatic pulse_sop();
        iwr_sop = 1'b1;
        tick();
        iwr_sop = 1'b0;
    endtask

    task automatic pulse_eop();
        iwr_eop = 1'b1;
        tick();
        iwr_eop = 1'b0;
    endtask

    task automatic pulse_eof();
        ich_eof = 1'b1;
        tick();
        ich_eof = 1'b0;
    endtask

    // Holds ibm_val until accepted; delay < 0 means the issue cycle is not checked.
    task automatic send_bm(input logic [PTR_W-1:0] p, input logic [PW-1:0] poly,
                           input int delay, output int acc_cyc);
        int   k;
        int   ecyc;
        logic acc;
        k   = 0;
        acc = 1'b0;
        ibm_val  = 1'b1;
        ibm_ptr  = p;
        ibm_poly = poly;
        while (!acc && k < 100) begin
            acc = obm_rdy;
            tick();
            k++;
        end
        ibm_val = 1'b0;
        acc_cyc = cyc;
        if (!acc) begin
            check_val("bm_accept_timeout", 64'(acc), 64'd1);
        end else begin
            ecyc = (delay < 0) ? -1 : cyc + delay;
            exp_q.push_back('{ptr: p, poly: poly, cyc: ecyc});
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) check_val("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int c2;

        // Reset state
        ireset_n = 1'b0;
        repeat (2) tick();
        check_val("rst_owr_rdy", 64'(owr_rdy), 64'd1);
        check_val("rst_owr_ptr", 64'(owr_ptr), 64'd0);
        ireset_n = 1'b1;
        tick();
        check_val("rst_obm_rdy", 64'(obm_rdy), 64'd1);
        check_val("rst_oerr", 64'(oerr), 64'd0);
        check_val("rst_obusy", 64'(obusy), 64'd0);
        check_val("rst_val", 64'(oloc_poly_val), 64'd0);
        check_val("rst_poly", 64'(oloc_poly), 64'd0);

        // Allocation, pool exhaustion, paced issue and release
        pulse_sop();
        check_val("alloc_ptr_adv", 64'(owr_ptr), 64'd1);
        check_val("rdy_fill_open", 64'(owr_rdy), 64'd0);
        pulse_eop();
        check_val("rdy_after_eop", 64'(owr_rdy), 64'd1);
        pulse_sop();
        pulse_eop();
        check_val("rdy_pool_full", 64'(owr_rdy), 64'd0);
        check_val("busy_pool_full", 64'(obusy), 64'd1);
        pulse_sop();
        check_val("err_sop_not_rdy", 64'(oerr), 64'd1);
        send_bm(1'b0, 32'h1234_5678, 1, c0);
        send_bm(1'b1, 32'h9abc_def0, 15, c1);
        check_val("bm_b2b_accept", 64'(c1), 64'(c0 + 1));
        repeat (3) tick();
        check_val("bm_rdy_wait", 64'(obm_rdy), 64'd0);
        wait_drain(40);
        pulse_eof();
        check_val("rel_owr_rdy", 64'(owr_rdy), 64'd1);
        check_val("rel_owr_ptr", 64'(owr_ptr), 64'd0);
        pulse_eof();
        check_val("rel_all_idle", 64'(obusy), 64'd0);
        check_val("err_sticky", 64'(oerr), 64'd1);

        // Release coincident with a third issue
        do_reset();
        pulse_sop();
        iwr_sop = 1'b1;
        iwr_eop = 1'b1;
        tick();
        iwr_sop = 1'b0;
        iwr_eop = 1'b0;
        check_val("sop_eop_same_ptr", 64'(owr_ptr), 64'd0);
        check_val("sop_eop_same_err", 64'(oerr), 64'd0);
        pulse_eop();
        send_bm(1'b0, 32'h0f1e_2d3c, 1, c0);
        send_bm(1'b1, 32'h4b5a_6978, 15, c1);
        send_bm(1'b0, 32'h8796_a5b4, 15, c2);
        check_val("third_issue_slot", 64'(c2 + 15), 64'(c0 + 31));
        while (cyc < c0 + 30) tick();
        pulse_eof();
        wait_drain(40);
        check_val("coinc_no_ovf", 64'(oerr), 64'b010);
        pulse_eof();
        pulse_eof();
        check_val("coinc_depth_idle", 64'(obusy), 64'd0);
        check_val("coinc_depth_err", 64'(oerr), 64'b010);
        pulse_eof();
        check_val("eof_empty_err", 64'(oerr), 64'b110);

        // BM result for FREE buffers, issue pacing across a clock-enable gap
        do_reset();
        send_bm(1'b0, 32'hcafe_f00d, 1, c0);
        check_val("err_bm_free", 64'(oerr), 64'b010);
        send_bm(1'b1, 32'h5a5a_a5a5, 20, c1);
        while (cyc < c0 + 4) tick();
        iclkena = 1'b0;
        repeat (5) tick();
        iclkena = 1'b1;
        wait_drain(60);
        check_val("busy_searching", 64'(obusy), 64'd1);

        // Asynchronous reset mid-search
        tick();
        @(posedge iclk);
        #3;
        ireset_n = 1'b0;
        #1;
        exp_q.delete();
        check_val("mid_rst_owr_rdy", 64'(owr_rdy), 64'd1);
        check_val("mid_rst_owr_ptr", 64'(owr_ptr), 64'd0);
        check_val("mid_rst_obm_rdy", 64'(obm_rdy), 64'd1);
        check_val("mid_rst_val", 64'(oloc_poly_val), 64'd0);
        check_val("mid_rst_ptr", 64'(oloc_poly_ptr), 64'd0);
        check_val("mid_rst_poly", 64'(oloc_poly), 64'd0);
        check_val("mid_rst_busy", 64'(obusy), 64'd0);
        check_val("mid_rst_err", 64'(oerr), 64'd0);
        tick();
        ireset_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bch_eras_buf_sched.md
# bch_eras_buf_sched

Buffer-pool scheduler for the BCH erasure decoder. It allocates frame RAM pointers to the input writer and tracks each buffer through fill, Berlekamp-Massey wait, ready and Chien-search. It holds one pair of locator polynomials from the BM stage and issues them to `bch_eras_chieny_search` at the search engine's acceptance rate. It frees each buffer on the Chien end-of-frame strobe.

## Interface
- `m`, 4: GF(2^m) order; sets `data_t` width.
- `n`, 15: codeword length; sets the minimum issue spacing.
- `d`, 7: code distance; t = (d-1)/2 sets the polynomial length.
- `ptr_w`, 1: pointer width; pool holds 2**ptr_w buffers; `ptr_t` = [ptr_w-1:0].
- `iclk` in 1: clock.
- `ireset_n` in 1: reset, asynchronous, active-low.
- `iclkena` in 1: clock enable; all state holds when low.
- `iwr_sop` in 1: writer requests a buffer; accepted when `owr_rdy`.
- `iwr_eop` in 1: writer finished filling the current buffer.
- `owr_rdy` out 1: the next round-robin buffer is FREE and no fill is open.
- `owr_ptr` out ptr_w: buffer assigned on accepted `iwr_sop`.
- `ibm_val` in 1: BM result valid.
- `ibm_ptr` in ptr_w: buffer the BM result belongs to.
- `ibm_poly` in data_t [2][0:t]: locator polynomials (no-erasure and erasure variants).
- `obm_rdy` out 1: holding register can accept.
- `oloc_poly_val` out 1: one-cycle start strobe to Chien.
- `oloc_poly_ptr` out ptr_w: buffer pointer for the search.
- `oloc_poly` out data_t [2][0:t]: polynomials, stable from issue until the next issue.
- `ich_eof` in 1: Chien `oeof`; releases the oldest searching buffer.
- `obusy` out 1: any buffer not FREE.
- `oerr` out 3: sticky protocol errors.

## Operation
- Per-buffer 2-bit state: FREE → FILL → WAIT_BM → SEARCH → FREE. A READY state is not used; the holding register represents it.
- Allocation: `alloc_ptr` is round-robin. On accepted `iwr_sop`, state[alloc_ptr]=FILL, `fill_ptr`=alloc_ptr, alloc_ptr+1 (wraps mod 2**ptr_w), and `fill_open` is set.
- `iwr_eop` with `fill_open`: state[fill_ptr]=WAIT_BM and `fill_open` clears.
  - `iwr_eop` and `iwr_sop` in the same cycle is legal. The eop is applied first, so `owr_rdy` is evaluated with `fill_open` cleared.
- BM handshake: `ibm_val & obm_rdy` loads the holding register and `hold_ptr`.
  - `obm_rdy` = ~hold_val | issue. This allows back-to-back transfers.
- Issue: `issue` = hold_val & ch_free.
  - Registers `oloc_poly`/`oloc_poly_ptr` and pulses `oloc_poly_val`.
  - state[hold_ptr]=SEARCH, and hold_ptr is pushed to a 2-entry search FIFO.
- `ch_free` models Chien readiness. A down-counter `gap` is loaded with n-1 on issue and decrements to 0 while `iclkena` is high. `ch_free` = (gap==0).
- Release: `ich_eof` pops the search FIFO and sets state[popped]=FREE. Release and issue in the same cycle are legal; the FIFO push and pop both apply.
- `oerr` bits:
  - [0] `iwr_sop` with `owr_rdy` low, or `iwr_eop` with no fill open.
  - [1] accepted BM result whose `ibm_ptr` state ≠ WAIT_BM. The result is still loaded.
  - [2] `ich_eof` with the search FIFO empty, or a push to a full FIFO.
- Errors never block operation; all bits are sticky until reset.

## Timing
- Reset values: all states FREE, alloc_ptr=0, gap=0, hold_val=0, FIFO empty.
  - Outputs after reset: `owr_rdy`=1, `owr_ptr`=0, `obm_rdy`=1, `oloc_poly_val`=0, `oloc_poly_ptr`=0, `oloc_poly`=0, `obusy`=0, `oerr`=0.
- `owr_rdy`, `owr_ptr`, `obm_rdy`, `obusy` are combinational from registers. `oloc_poly_val` is registered.
- BM accept at cycle C → earliest `oloc_poly_val` at C+1 (holding register) when `ch_free`.
- Successive `oloc_poly_val` pulses are exactly n enabled cycles apart under continuous load. This matches Chien restart on `cnt_is_n`.
- State update on `iwr_sop` is visible to `owr_rdy` in the next cycle.
- Reset asserted mid-frame discards all state immediately; the pool returns to the reset values above.
- With `iclkena` low, no handshake completes and `oloc_poly_val` holds. The Chien search block shares the same `iclkena`.

## Structure
- Shared package `bch_eras_pkg`: `buf_state_t` enum, `ptr_t`, `data_t`, `t` derivation.
- One sub-module, `bch_eras_ptr_fifo`: the 2-entry search FIFO (push, pop, full/empty, head).

## Test plan
- Reset → `owr_rdy`=1, `owr_ptr`=0, `obm_rdy`=1, `oerr`=0, `obusy`=0.
- ptr_w=1: sop/eop for frames 0 and 1, then a third sop → `owr_rdy`=0 and `oerr[0]`=1; `ich_eof` frees ptr 0 → `owr_rdy`=1, `owr_ptr`=0.
- n=15: two BM results on consecutive cycles → `oloc_poly_val` at C+1 and C+16, with ptrs 0 then 1; `obm_rdy` low during the wait.
- `ich_eof` coincident with a third issue → FIFO depth stays 2 and `oerr[2]`=0.
- BM result for a FREE buffer → `oerr[1]`=1; the polynomial is still issued.
- `ireset_n` pulsed low mid-search → all outputs return to reset values within the same cycle.
